// File: rtl/binary_acc_14_pkg.sv
// Shared types and defaults for the binary adder/accumulator family.
// Holds the accumulator FSM state encoding and the width-derivation helper.
package binary_add_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } acc_state_t;

    localparam int DEF_DATA_W  = 14;
    localparam int DEF_N_TERMS = 8;
    localparam int DEF_CNT_W   = 8;

    // Ceiling log2; clog2(1) is 0 so a single-term build adds no guard bits.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/binary_acc_14_if.sv
// Stream bus between the adder stage, the accumulator and its consumer.
// Carries the input term stream, the held result stream and a debug view of the FSM state.
interface binary_acc_14_if
    import binary_add_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_DATA_W + clog2(DEF_N_TERMS)
);

    // Both streams are valid/ready: a transfer happens on a rising clock edge where
    // valid and ready are both 1; once valid is raised the sender keeps it and its
    // data unchanged until that edge, and ready never depends on valid.
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [ACC_W-1:0]  out_data;
    logic              out_ready;
    logic              ovf;
    acc_state_t        dbg_state;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, ovf, dbg_state
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, ovf, dbg_state
    );

endinterface

// File: rtl/binary_acc_14_acc_rca.sv
// Ripple-carry adder of W bits built as a chain of full-adder cells, carry-in tied low.
// The final carry is exposed so the accumulator can flag overflow.
module acc_rca #(
    parameter int W = 17
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         cout
);

    // Carry walks the cell chain as a procedural variable to keep it a plain ripple.
    always_comb begin : fa_chain
        logic carry;
        carry = 1'b0;
        sum   = '0;
        for (int i = 0; i < W; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/binary_acc_14.sv
// Accumulates N_TERMS unsigned sums into a wider total and holds it until consumed.
// Build option BINARY_ACC_SAT_EN: clamp to all-ones on overflow instead of wrapping.
module binary_acc_14
    import binary_add_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int N_TERMS = DEF_N_TERMS,
    parameter int ACC_W   = DATA_W + clog2(N_TERMS),
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    binary_acc_14_if.slave bus
);

    acc_state_t       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic             ovf_q, ovf_d;

    logic             in_ready;
    logic             accept;
    logic             last_term;
    logic [ACC_W-1:0] in_ext;
    logic [ACC_W-1:0] sum_raw;
    logic [ACC_W-1:0] next_acc;
    logic             sum_cout;

    assign in_ready  = (state_q != HOLD);
    assign accept    = bus.in_valid && in_ready;
    assign in_ext    = ACC_W'(bus.in_data);
    assign last_term = (cnt_q == CNT_W'(N_TERMS - 1));

    acc_rca #(
        .W (ACC_W)
    ) u_rca (
        .a    (acc_q),
        .b    (in_ext),
        .sum  (sum_raw),
        .cout (sum_cout)
    );

`ifdef BINARY_ACC_SAT_EN
    // Once overflowed, the accumulation stays pinned at full scale until it completes.
    assign next_acc = (sum_cout || ovf_q) ? {ACC_W{1'b1}} : sum_raw;
`else
    assign next_acc = sum_raw;
`endif

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        ovf_d       = ovf_q;

        if (clr) begin
            // Abort discards partial and pending results but leaves out_data as last shown.
            state_d     = IDLE;
            acc_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            ovf_d       = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        acc_d = in_ext;
                        ovf_d = 1'b0;
                        cnt_d = CNT_W'(1);
                        if (N_TERMS == 1) begin
                            out_data_d  = in_ext;
                            out_valid_d = 1'b1;
                            state_d     = HOLD;
                        end else begin
                            state_d = ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        ovf_d = ovf_q | sum_cout;
                        acc_d = next_acc;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (last_term) begin
                            out_data_d  = next_acc;
                            out_valid_d = 1'b1;
                            state_d     = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_d = 1'b0;
                        cnt_d       = '0;
                        state_d     = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.ovf       = ovf_q;
    assign bus.dbg_state = state_q;

endmodule

// File: doc/binary_acc_14.md
Name: binary_acc_14

Overview:
- Downstream consumer of the 14-bit registered adder stage.
- Takes a stream of 14-bit sums over a valid/ready handshake and accumulates N_TERMS of them into a wider accumulator.
- Presents each completed total on a held valid/ready output.
- Used for block sums and averaging front-ends; carry-out of the adder stage is not needed because the accumulator is widened.

Parameters:
- DATA_W, 14, width of each incoming sum.
- N_TERMS, 8, terms per accumulation; legal range 1..256.
- ACC_W, 17, accumulator/output width; default is DATA_W + clog2(N_TERMS), so it cannot overflow at defaults.
- CNT_W, 8, term counter width; must hold N_TERMS-1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous abort/clear.
- in_valid  in  1  in_data is valid this cycle.
- in_data  in  DATA_W  sum from the adder stage, unsigned.
- in_ready  out  1  block accepts in_data this cycle.
- out_valid  out  1  out_data holds a completed total.
- out_data  out  ACC_W  accumulated total.
- out_ready  in  1  downstream consumes out_data.
- ovf  out  1  accumulation overflowed ACC_W; valid alongside out_valid.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, acc=0, cnt=0, out_valid=0, out_data=0, ovf=0. in_ready is 1 once rst_n is released.
- Accept = in_valid && in_ready. in_ready is 1 in IDLE and ACCUM, 0 in HOLD. in_ready is combinational from state only, never from in_valid.
- FSM IDLE:
  - On accept: acc <= zero-extended in_data, ovf <= 0, cnt <= 1.
  - If N_TERMS==1, go to HOLD with out_data <= in_data; otherwise go to ACCUM.
- FSM ACCUM:
  - On accept: sum = acc + zero-extended in_data at ACC_W+1 bits.
  - Bit ACC_W of sum set -> overflow event: ovf <= 1 (sticky for this accumulation).
  - acc <= sum[ACC_W-1:0] (wrap), cnt <= cnt+1.
  - When the accepted term is term number N_TERMS (cnt==N_TERMS-1 before increment): out_data <= new acc, out_valid <= 1, go to HOLD.
  - No accept: hold everything.
- FSM HOLD:
  - out_valid=1; out_data and ovf are stable.
  - When out_ready=1: out_valid <= 0, cnt <= 0, go to IDLE. The next accept is possible the following cycle.
- Latency: out_valid rises on the clock edge that accepts the final term, so it is visible the cycle after that term's handshake.
- Throughput: one term per cycle; one idle input cycle per result (the HOLD cycle).
- out_data is registered; it changes only on entry to HOLD or on reset.
- clr: highest synchronous priority, overriding accept and out_ready in the same cycle. Effect: state IDLE, acc=0, cnt=0, out_valid=0, ovf=0; any partial sum or pending result is discarded. out_data keeps its last value.
- rst_n asserted mid-accumulation or in HOLD: immediate return to reset values; no partial result is emitted.
- in_valid high in HOLD: no accept; upstream must hold its data (standard valid/ready, no drop).
- Inputs are treated as unsigned; no sign extension.

Optional Feature:
- Macro: BINARY_ACC_SAT_EN.
- Defined: on an overflow event, acc and every later sum in the same accumulation clamp to all-ones of ACC_W; out_data is {ACC_W{1'b1}}; ovf=1.
- Undefined: modular wrap as described above; ovf still flags it.
- Port list is identical in both builds.

Decomposition:
- Shared package binary_add_pkg:
  - state enum typedef acc_state_t {IDLE, ACCUM, HOLD}.
  - localparam defaults DATA_W=14, N_TERMS=8.
  - Function clog2 for ACC_W/CNT_W derivation.
- One sub-module, acc_rca:
  - Parameterised ACC_W-bit ripple-carry adder built from the existing FA cell chain.
  - Ports a, b, sum, cout; Cin tied 0.
  - cout feeds overflow detection.
- FSM, counter and saturation mux stay in binary_acc_14.

Test Plan:
- Defaults, 8 back-to-back terms of 14'h3FFF, out_ready=1 -> out_valid one cycle after the 8th accept; out_data=17'h1FFF8 (131064); ovf=0; in_ready low exactly one cycle.
- Defaults, terms 1..8 with in_valid toggling every other cycle -> out_data=36 after the 8th accept; in_ready never drops during ACCUM gaps.
- out_ready held 0 for 5 cycles after completion -> out_valid and out_data (36) stable; in_ready=0; in_valid held high with data 7 is not accepted until out_ready=1; the next result includes that 7.
- ACC_W=15, N_TERMS=3, three terms of 16383, macro undefined -> out_data=16381, ovf=1. With BINARY_ACC_SAT_EN defined -> out_data=32767, ovf=1.
- clr pulsed after 4 terms of 100, then 8 terms of 1 -> only out_data=8 is produced; no intermediate out_valid.
- rst_n asserted asynchronously in HOLD (mid-cycle, no clock edge) -> out_valid, out_data and ovf go to 0 immediately; after release, the first result depends only on post-reset terms.
